// File: rtl/mult_acc_pipe.sv
// mult_acc_pipe: pipelined signed/unsigned multiply-accumulate with
// clock-enable stall, bubble tracking, accumulate/clear modes and saturation.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (overrides ce)
//   ce        clock enable; 0 freezes every register
//   in_valid  a/b and mode bits are valid this cycle
//   a, b      operands (ASIZE / BSIZE bits)
//   a_signed  1 = a is two's complement, 0 = unsigned
//   b_signed  1 = b is two's complement, 0 = unsigned
//   acc_en    1 = add product to accumulator, 0 = load product
//   acc_clr   with acc_en: start a new sum
//   out_valid p is valid this cycle
//   p         signed result (OSIZE bits)
//   acc_ovf   sticky accumulator overflow flag
module mult_acc_pipe #(
    parameter int ASIZE       = 16,
    parameter int BSIZE       = 16,
    parameter int PIPE_STAGES = 3,
    parameter int ACC_SIZE    = 48,
    parameter int OSIZE       = 32,
    parameter int SAT_EN      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [ASIZE-1:0] a,
    input  logic [BSIZE-1:0] b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic [OSIZE-1:0] p,
    output logic             acc_ovf
);

    // One extra bit per operand makes the product exact for every
    // signedness combination in ASIZE+BSIZE+1 bits.
    localparam int PW = ASIZE + BSIZE + 1;
    localparam int AW = ACC_SIZE;

    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [OSIZE-1:0] OUT_MAX = {1'b0, {(OSIZE-1){1'b1}}};
    localparam logic [OSIZE-1:0] OUT_MIN = {1'b1, {(OSIZE-1){1'b0}}};

    logic signed [PW-1:0] w_ae;
    logic signed [PW-1:0] w_be;
    logic signed [PW-1:0] w_prod;

    assign w_ae   = {{(PW-ASIZE){a_signed & a[ASIZE-1]}}, a};
    assign w_be   = {{(PW-BSIZE){b_signed & b[BSIZE-1]}}, b};
    assign w_prod = w_ae * w_be;

    logic [PW-1:0]          r_prod [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_vld;
    logic [PIPE_STAGES-1:0] r_en;
    logic [PIPE_STAGES-1:0] r_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_prod[i] <= '0;
            end
            r_vld <= '0;
            r_en  <= '0;
            r_clr <= '0;
        end else if (ce) begin
            r_prod[0] <= w_prod;
            r_vld[0]  <= in_valid;
            r_en[0]   <= acc_en;
            r_clr[0]  <= acc_clr;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_vld[i]  <= r_vld[i-1];
                r_en[i]   <= r_en[i-1];
                r_clr[i]  <= r_clr[i-1];
            end
        end
    end

    logic [PW-1:0] w_lp;
    logic          w_lv;
    logic          w_len;
    logic          w_lclr;

    assign w_lp   = r_prod[PIPE_STAGES-1];
    assign w_lv   = r_vld[PIPE_STAGES-1];
    assign w_len  = r_en[PIPE_STAGES-1];
    assign w_lclr = r_clr[PIPE_STAGES-1];

    logic [AW-1:0]    r_acc;
    logic [OSIZE-1:0] r_p;
    logic             r_ovf;
    logic             r_out_valid;

    logic [AW-1:0]     w_base;
    logic [AW:0]       w_sum;
    logic              w_ovf;
    logic [AW-1:0]     w_acc_nx;
    logic [AW-OSIZE:0] w_hi;
    logic [OSIZE-1:0]  w_p_nx;

    // Bits above the OSIZE sign bit must all match it for p to fit.
    assign w_hi = w_acc_nx[AW-1:OSIZE-1];

    always_comb begin
        w_base   = (w_len & ~w_lclr) ? r_acc : '0;
        w_sum    = {w_base[AW-1], w_base}
                 + {{(AW+1-PW){w_lp[PW-1]}}, w_lp};
        w_ovf    = w_sum[AW] ^ w_sum[AW-1];
        w_acc_nx = w_sum[AW-1:0];
        if (SAT_EN != 0 && w_ovf) begin
            w_acc_nx = w_sum[AW] ? ACC_MIN : ACC_MAX;
        end
        w_p_nx = w_acc_nx[OSIZE-1:0];
        if (SAT_EN != 0 && !(&w_hi) && (|w_hi)) begin
            w_p_nx = w_acc_nx[AW-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (ce) begin
            r_out_valid <= w_lv;
            if (w_lv) begin
                r_acc <= w_acc_nx;
                r_p   <= w_p_nx;
                if (w_ovf) begin
                    r_ovf <= 1'b1;
                end else if (!w_len || w_lclr) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign p         = r_p;
    assign acc_ovf   = r_ovf;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// tb_mult_acc_pipe: scoreboard bench for mult_acc_pipe on three builds
// (default, SAT_EN=0, ACC_SIZE=33) sharing operand buses.
module tb_mult_acc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [15:0] a;
    logic [15:0] b;
    logic        a_s;
    logic        b_s;
    logic        acc_en;
    logic        acc_clr;
    logic [2:0]  vin;

    logic        ov  [3];
    logic [31:0] pp  [3];
    logic        ovf [3];

    always #5 clk = ~clk;

    mult_acc_pipe dut0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(vin[0]),
        .a(a), .b(b), .a_signed(a_s), .b_signed(b_s),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(ov[0]), .p(pp[0]), .acc_ovf(ovf[0])
    );

    mult_acc_pipe #(.SAT_EN(0)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(vin[1]),
        .a(a), .b(b), .a_signed(a_s), .b_signed(b_s),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(ov[1]), .p(pp[1]), .acc_ovf(ovf[1])
    );

    mult_acc_pipe #(.ACC_SIZE(33)) dut2 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(vin[2]),
        .a(a), .b(b), .a_signed(a_s), .b_signed(b_s),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(ov[2]), .p(pp[2]), .acc_ovf(ovf[2])
    );

    typedef struct {
        logic [31:0] p;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q [3][$];

    int   checks  = 0;
    int   errors  = 0;
    int   ecnt    = 0;
    logic last_en = 1'b0;

    // Enabled-cycle counter: latency is measured in ce=1 cycles only.
    always @(posedge clk) begin
        last_en <= ce && !rst;
        if (ce && !rst) ecnt <= ecnt + 1;
    end

    task automatic mon(input int k);
        exp_t e;
        if (ov[k]) begin
            checks++;
            if (q[k].size() == 0) begin
                errors++;
                $display("FAIL unexpected_out dut%0d p=%h ovf=%b",
                         k, pp[k], ovf[k]);
            end else begin
                e = q[k].pop_front();
                if (pp[k] !== e.p || ovf[k] !== e.ovf || ecnt != e.cyc) begin
                    errors++;
                    $display("FAIL out dut%0d got p=%h ovf=%b cyc=%0d exp p=%h ovf=%b cyc=%0d",
                             k, pp[k], ovf[k], ecnt, e.p, e.ovf, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (last_en) begin
            mon(0);
            mon(1);
            mon(2);
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic issue(input int k, input logic [15:0] av,
                         input logic [15:0] bv, input logic as_,
                         input logic bs_, input logic en, input logic clr,
                         input logic [31:0] ep, input logic eo);
        exp_t e;
        a       = av;
        b       = bv;
        a_s     = as_;
        b_s     = bs_;
        acc_en  = en;
        acc_clr = clr;
        vin     = '0;
        vin[k]  = 1'b1;
        e.p     = ep;
        e.ovf   = eo;
        e.cyc   = ecnt + 4;
        q[k].push_back(e);
        @(posedge clk);
        #1;
        vin = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0",
                     q[0].size() + q[1].size() + q[2].size());
        end
        tick(2);
    endtask

    task automatic sat_run();
        issue(2, 16'h7FFF, 16'h7FFF, 1, 1, 1, 1, 32'h3FFF0001, 0);
        issue(2, 16'h7FFF, 16'h7FFF, 1, 1, 1, 0, 32'h7FFE0002, 0);
        issue(2, 16'h7FFF, 16'h7FFF, 1, 1, 1, 0, 32'h7FFFFFFF, 0);
        issue(2, 16'h7FFF, 16'h7FFF, 1, 1, 1, 0, 32'h7FFFFFFF, 0);
        issue(2, 16'h7FFF, 16'h7FFF, 1, 1, 1, 0, 32'h7FFFFFFF, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; vin = '0;
        a = '0; b = '0; a_s = 0; b_s = 0; acc_en = 0; acc_clr = 0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", 32'(ov[k]), 32'h0);
            chk("reset_p", pp[k], 32'h0);
            chk("reset_ovf", 32'(ovf[k]), 32'h0);
        end
        @(posedge clk); #1;

        issue(0, 16'hFFFD, 16'h0007, 1, 1, 0, 0, 32'hFFFFFFEB, 0);
        issue(0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 32'h7FFFFFFF, 0);
        issue(1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 32'hFFFE0001, 0);
        issue(0, 16'h8000, 16'hFFFF, 1, 0, 0, 0, 32'h80008000, 0);
        issue(0, 16'h8000, 16'hFFFF, 1, 0, 1, 0, 32'h80000000, 0);
        issue(0, 16'h8000, 16'h8000, 1, 1, 0, 0, 32'h40000000, 0);
        drain();

        issue(0, 16'd100, 16'd200, 1, 1, 1, 1, 32'd20000, 0);
        issue(0, 16'd100, 16'd200, 1, 1, 1, 0, 32'd40000, 0);
        issue(0, 16'd100, 16'd200, 1, 1, 1, 0, 32'd60000, 0);
        issue(0, 16'd100, 16'd200, 1, 1, 1, 0, 32'd80000, 0);
        issue(0, 16'd100, 16'd200, 1, 1, 1, 1, 32'd20000, 0);
        drain();

        issue(0, 16'd100, 16'd200, 1, 1, 1, 1, 32'd20000, 0);
        issue(0, 16'd100, 16'd200, 1, 1, 1, 0, 32'd40000, 0);
        ce = 1'b0;
        tick(3);
        ce = 1'b1;
        issue(0, 16'd100, 16'd200, 1, 1, 1, 0, 32'd60000, 0);
        issue(0, 16'd100, 16'd200, 1, 1, 1, 0, 32'd80000, 0);
        drain();

        issue(0, 16'd3, 16'd4, 1, 1, 0, 0, 32'd12, 0);
        a = 16'd100; b = 16'd100; acc_en = 1; acc_clr = 0;
        tick(1);
        issue(0, 16'd2, 16'd5, 1, 1, 1, 0, 32'd22, 0);
        drain();

        issue(1, 16'h7FFF, 16'h7FFF, 1, 1, 1, 1, 32'h3FFF0001, 0);
        issue(1, 16'h7FFF, 16'h7FFF, 1, 1, 1, 0, 32'h7FFE0002, 0);
        issue(1, 16'h7FFF, 16'h7FFF, 1, 1, 1, 0, 32'hBFFD0003, 0);
        drain();

        sat_run();
        issue(2, 16'h0001, 16'hFFFF, 1, 1, 1, 0, 32'h7FFFFFFF, 1);
        issue(2, 16'h0001, 16'h0001, 1, 1, 1, 1, 32'h00000001, 0);
        drain();
        sat_run();
        drain();

        issue(0, 16'd7, 16'd9, 1, 1, 0, 0, 32'd63, 0);
        issue(0, 16'd5, 16'd9, 1, 1, 0, 0, 32'd45, 0);
        issue(0, 16'd3, 16'd9, 1, 1, 0, 0, 32'd27, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) q[k].delete();
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", 32'(ov[k]), 32'h0);
            chk("rst_p", pp[k], 32'h0);
            chk("rst_ovf", 32'(ovf[k]), 32'h0);
        end
        @(posedge clk); #1;
        tick(8);

        issue(0, 16'd11, 16'd11, 1, 1, 0, 0, 32'd121, 0);
        drain();
        issue(0, 16'd7, 16'd9, 1, 1, 0, 0, 32'd63, 0);
        issue(0, 16'd5, 16'd9, 1, 1, 0, 0, 32'd45, 0);
        issue(0, 16'd3, 16'd9, 1, 1, 0, 0, 32'd27, 0);
        rst = 1'b1;
        ce  = 1'b0;
        for (int k = 0; k < 3; k++) q[k].delete();
        tick(1);
        rst = 1'b0;
        ce  = 1'b1;
        @(negedge clk);
        chk("rst_ce0_valid", 32'(ov[0]), 32'h0);
        chk("rst_ce0_p", pp[0], 32'h0);
        chk("rst_ce0_ovf", 32'(ovf[0]), 32'h0);
        @(posedge clk); #1;
        tick(8);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
